// File: rtl/neural_pkg.sv
// Shared constants, vector types and saturation helpers for the 4x2 layer.
// Optional ReLU output stage is selected by NEURAL_RELU_EN.
package neural_pkg;

  localparam int NUM_IN  = 4;
  localparam int NUM_OUT = 2;
  localparam int IN_W    = 8;
  localparam int OUT_W   = 16;
  localparam int ACC_W   = 18;

  localparam logic [3:0] W_BASE = 4'd0;
  localparam logic [3:0] B_BASE = 4'd8;

  typedef logic signed [IN_W-1:0]  in_vec_t  [NUM_IN];
  typedef logic signed [OUT_W-1:0] out_vec_t [NUM_OUT];

  // Out of range when the bits above the output sign are not a pure
  // sign extension.
  function automatic logic is_ovf(
    input logic signed [ACC_W-1:0] a
  );
    logic [ACC_W-OUT_W:0] top;
    top = a[ACC_W-1:OUT_W-1];
    return !((&top) || !(|top));
  endfunction

  function automatic logic signed [OUT_W-1:0] sat16(
    input logic signed [ACC_W-1:0] a
  );
    if (!is_ovf(a))
      return a[OUT_W-1:0];
    if (a[ACC_W-1])
      return {1'b1, {(OUT_W-1){1'b0}}};
    return {1'b0, {(OUT_W-1){1'b1}}};
  endfunction

endpackage

// File: rtl/neural_mac4.sv
// One neuron: four multipliers, registered products and bias, then sum and
// saturation (ReLU applied after saturation when NEURAL_RELU_EN is defined).
module neural_mac4
  import neural_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  parameter int ACC_W = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld,
  input  logic signed [IN_W-1:0]  x [NUM_IN],
  input  logic signed [IN_W-1:0]  w [NUM_IN],
  input  logic signed [IN_W-1:0]  b,
  output logic signed [OUT_W-1:0] y,
  output logic                    sat
);

  logic signed [2*IN_W-1:0] p_d [NUM_IN];
  logic signed [2*IN_W-1:0] p_q [NUM_IN];
  logic signed [IN_W-1:0]   b_q;
  logic signed [ACC_W-1:0]  acc;

  always_comb begin
    for (int i = 0; i < NUM_IN; i++)
      p_d[i] = x[i] * w[i];
  end

  // Bias is captured with the products so a sample sees one
  // consistent snapshot of the register file.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_IN; i++)
        p_q[i] <= '0;
      b_q <= '0;
    end else if (ld) begin
      p_q <= p_d;
      b_q <= b;
    end
  end

  always_comb begin
    acc = ACC_W'(b_q);
    for (int i = 0; i < NUM_IN; i++)
      acc = acc + ACC_W'(p_q[i]);
    sat = is_ovf(acc);
    y   = sat16(acc);
`ifdef NEURAL_RELU_EN
    if (y[OUT_W-1])
      y = '0;
`endif
  end

endmodule

// File: rtl/neural_layer_core.sv
// Fully connected 4-input, 2-neuron layer, 3-cycle latency, 1 sample/cycle.
// Optional ReLU output stage is selected by NEURAL_RELU_EN.
module neural_layer_core
  import neural_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  parameter int ACC_W = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    input_valid,
  input  logic signed [IN_W-1:0]  input_data [NUM_IN],
  input  logic                    w_we,
  input  logic [3:0]              w_addr,
  input  logic signed [IN_W-1:0]  w_data,
  output logic                    output_valid,
  output logic signed [OUT_W-1:0] output_data [NUM_OUT],
  output logic                    sat_flag
);

  logic                   v1;
  logic                   v2;
  in_vec_t                x1;
  logic signed [IN_W-1:0] wt   [NUM_OUT][NUM_IN];
  logic signed [IN_W-1:0] bias [NUM_OUT];
  out_vec_t               y_d;
  logic [NUM_OUT-1:0]     s_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      v1           <= 1'b0;
      v2           <= 1'b0;
      output_valid <= 1'b0;
    end else begin
      v1           <= input_valid;
      v2           <= v1;
      output_valid <= v2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_IN; i++)
        x1[i] <= '0;
    end else if (input_valid) begin
      x1 <= input_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int j = 0; j < NUM_OUT; j++) begin
        bias[j] <= '0;
        for (int i = 0; i < NUM_IN; i++)
          wt[j][i] <= '0;
      end
    end else if (w_we) begin
      unique case (1'b1)
        (w_addr < B_BASE):
          wt[w_addr[2]][w_addr[1:0]] <= w_data;
        (w_addr == B_BASE):
          bias[0] <= w_data;
        (w_addr == B_BASE + 4'd1):
          bias[1] <= w_data;
        default: ;
      endcase
    end
  end

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_neuron
    neural_mac4 #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .ACC_W (ACC_W)
    ) u_mac (
      .clk (clk),
      .rst (rst),
      .ld  (v1),
      .x   (x1),
      .w   (wt[j]),
      .b   (bias[j]),
      .y   (y_d[j]),
      .sat (s_d[j])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int j = 0; j < NUM_OUT; j++)
        output_data[j] <= '0;
      sat_flag <= 1'b0;
    end else if (v2) begin
      output_data <= y_d;
      sat_flag    <= |s_d;
    end
  end

endmodule

// File: tb/tb_neural_layer_core.sv
// Randomised and directed bench for neural_layer_core against an
// arithmetic reference model with a due-cycle scoreboard.
module tb_neural_layer_core;
  import neural_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b0;
  logic              input_valid = 1'b0;
  logic signed [7:0] input_data [NUM_IN];
  logic              w_we = 1'b0;
  logic [3:0]        w_addr = '0;
  logic signed [7:0] w_data = '0;
  logic              output_valid;
  logic signed [15:0] output_data [NUM_OUT];
  logic              sat_flag;

  neural_layer_core dut (
    .clk          (clk),
    .rst          (rst),
    .input_valid  (input_valid),
    .input_data   (input_data),
    .w_we         (w_we),
    .w_addr       (w_addr),
    .w_data       (w_data),
    .output_valid (output_valid),
    .output_data  (output_data),
    .sat_flag     (sat_flag)
  );

  typedef struct {
    int due;
    int y0;
    int y1;
    int s;
  } exp_t;

  exp_t q[$];
  int   mw [2][4];
  int   mb [2];
  int   last0 = 0;
  int   last1 = 0;
  int   ecnt = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0d expected %0d",
               tag, ecnt, obs, exp);
    end
  endtask

  function automatic int sx(input int d);
    logic signed [7:0] t;
    t = 8'(d);
    return int'(t);
  endfunction

  task automatic check_out();
    if (q.size() > 0 && q[0].due == ecnt) begin
      chk("valid", output_valid, 1);
      chk("y0", output_data[0], q[0].y0);
      chk("y1", output_data[1], q[0].y1);
      chk("sat", sat_flag, q[0].s);
      last0 = q[0].y0;
      last1 = q[0].y1;
      void'(q.pop_front());
    end else begin
      chk("idle_valid", output_valid, 0);
      chk("hold_y0", output_data[0], last0);
      chk("hold_y1", output_data[1], last1);
    end
  endtask

  task automatic tick(input bit rn, input bit v,
                      input int x0, input int x1,
                      input int x2, input int x3,
                      input bit we, input int a, input int d);
    int xs [4];
    int acc, y, s;
    exp_t e;
    @(negedge clk);
    if (ecnt >= 1) check_out();
    rst = rn;
    input_valid = v;
    input_data[0] = 8'(x0);
    input_data[1] = 8'(x1);
    input_data[2] = 8'(x2);
    input_data[3] = 8'(x3);
    w_we = we;
    w_addr = 4'(a);
    w_data = 8'(d);
    if (!rn) begin
      q.delete();
      for (int j = 0; j < 2; j++) begin
        mb[j] = 0;
        for (int i = 0; i < 4; i++) mw[j][i] = 0;
      end
      last0 = 0;
      last1 = 0;
    end else begin
      if (we) begin
        if (a < 8) mw[a / 4][a % 4] = sx(d);
        else if (a == 8) mb[0] = sx(d);
        else if (a == 9) mb[1] = sx(d);
      end
      if (v) begin
        xs[0] = sx(x0); xs[1] = sx(x1);
        xs[2] = sx(x2); xs[3] = sx(x3);
        e.due = ecnt + 3;
        e.s = 0;
        for (int j = 0; j < 2; j++) begin
          acc = mb[j];
          for (int i = 0; i < 4; i++) acc += mw[j][i] * xs[i];
          if (acc > 32767 || acc < -32768) e.s = 1;
          y = (acc > 32767) ? 32767 : (acc < -32768) ? -32768 : acc;
`ifdef NEURAL_RELU_EN
          if (y < 0) y = 0;
`endif
          if (j == 0) e.y0 = y; else e.y1 = y;
        end
        q.push_back(e);
      end
    end
  endtask

  task automatic wr(input int a, input int d);
    tick(1, 0, 0, 0, 0, 0, 1, a, d);
  endtask

  task automatic smp(input int x0, input int x1, input int x2, input int x3);
    tick(1, 1, x0, x1, x2, x3, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic int rx();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  initial begin
    for (int i = 0; i < NUM_IN; i++) input_data[i] = '0;
    for (int k = 0; k < 3; k++) tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // identity load
    wr(0, 1);
    wr(5, 1);
    smp(5, -3, 7, 2);
    idle(4);

    // positive saturation
    for (int a = 0; a < 8; a++) wr(a, -128);
    wr(8, 100);
    smp(-128, -128, -128, -128);
    idle(4);

    // negative saturation on neuron 1
    for (int a = 4; a < 8; a++) wr(a, 127);
    smp(-128, -128, -128, -128);
    idle(4);

    // streaming
    for (int a = 0; a < 8; a++) wr(a, 1);
    wr(8, 0);
    wr(9, -1);
    for (int k = 1; k <= 4; k++) smp(k, k, k, k);
    idle(5);

    // weight update mid-stream: before, same cycle, after
    smp(3, 0, 0, 0);
    tick(1, 1, 3, 0, 0, 0, 1, 0, 2);
    smp(3, 0, 0, 0);
    idle(4);

    // writes above 9 are ignored
    for (int a = 10; a < 16; a++) wr(a, 77);
    smp(1, 2, 3, 4);
    idle(4);

    // reset mid-stream
    smp(9, 9, 9, 9);
    smp(8, 8, 8, 8);
    tick(0, 1, 7, 7, 7, 7, 1, 0, 5);
    idle(5);
    smp(100, -50, 25, 3);
    idle(4);

    for (int k = 0; k < 600; k++) begin
      bit rn, v, we;
      rn = ($urandom_range(0, 149) != 0);
      v  = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 3) == 0);
      tick(rn, v, rx(), rx(), rx(), rx(), we,
           int'($urandom_range(0, 15)), rx());
    end
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/neural_layer_core.md
# neural_layer_core

Fully connected 4-input, 2-neuron inference layer. It sits on the DUT side of `neural_if` and consumes `input_valid`/`input_data[4]`. It produces `output_valid`/`output_data[2]` with a fixed 3-cycle latency and accepts one sample per cycle. Weights and biases are loaded through a separate register-write port, and outputs are saturated to 16 bits.

## Interface
Parameters:
- `IN_W`, 8: signed input, weight and bias width.
- `OUT_W`, 16: signed output width.
- `ACC_W`, 18: signed accumulator width. Holds a 4-term sum of IN_W×IN_W products plus bias without overflow.

Ports:
- `clk`  in  1  clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `input_valid`  in  1  sample present this cycle; no backpressure.
- `input_data[4]`  in  4×IN_W signed  input vector x[0..3].
- `w_we`  in  1  weight/bias register write strobe.
- `w_addr`  in  4  0–7 select weight w[j][i] at address j*4+i; 8 selects b[0]; 9 selects b[1]; 10–15 writes are ignored.
- `w_data`  in  IN_W signed  write data.
- `output_valid`  out  1  result present this cycle.
- `output_data[2]`  out  2×OUT_W signed  result y[0..1].
- `sat_flag`  out  1  at least one of the two neurons saturated in this result; qualified by output_valid.

## Operation
- Each neuron computes y[j] = sat16( Σ_i w[j][i]·x[i] + sext(b[j]) ), for j = 0..1.
- Products are IN_W×IN_W signed, giving 2·IN_W bits. They are sign-extended to ACC_W before the sum.
- Bias is sign-extended from IN_W; it is not shifted.
- Saturation clamps to the range [−32768, +32767].
  - sat_flag = OR over j of (accumulator outside that range).
  - With the ReLU option, the flag is evaluated before ReLU.
- Three-stage pipeline:
  - S1: register x and the valid bit.
  - S2: register the 8 products and the valid bit.
  - S3: add bias, sum, saturate (and apply ReLU when enabled), then register the outputs and valid.
- The pipeline has no stall or state machine. Each stage has a valid bit. Data registers load only when the stage's incoming valid is 1; otherwise they hold.
- Register file: 8 weights plus 2 biases.
  - A write in cycle c updates the register at the end of c.
  - The new value is visible to the S2 multiply from cycle c+1.
  - A sample whose S1 occupancy is in cycle c+1 or later uses the new value.
- Reset (rst=0 sampled at an edge) clears:
  - all valid bits;
  - output_data, sat_flag and output_valid, to 0;
  - all weights and biases, to 0.
- A reset during streaming discards all in-flight samples; none appear after reset. Inputs presented while rst=0 are ignored.
- A w_we and an input_valid in the same cycle are both accepted.

## Timing
- input_valid=1 in cycle c produces output_valid=1 in cycle c+3, with output_data and sat_flag valid in that cycle.
- Throughput is one sample per cycle. N consecutive valid inputs give N consecutive valid outputs, in order.
- output_valid is high for exactly one cycle per accepted sample.
- output_data holds its last value while output_valid=0.
- Weight write-to-use latency is 1 cycle, measured to the S2 stage.

## Configuration
- Macro: `NEURAL_RELU_EN`.
- When defined, S3 outputs max(0, sat16(acc)): negative results become 0, and sat_flag is still computed from the pre-ReLU accumulator.
- When undefined, the output is the saturated linear value. No ReLU logic is compiled.

## Structure
- `neural_pkg` contains:
  - constants NUM_IN=4, NUM_OUT=2, IN_W, OUT_W, ACC_W;
  - typedefs `in_vec_t` and `out_vec_t`;
  - the weight-file address constants W_BASE=0 and B_BASE=8;
  - a `sat16` function.
- `neural_mac4` is one neuron: 4 multipliers, the S2 product register, the adder and saturation. `neural_layer_core` instantiates it NUM_OUT times. The top level holds the S1 register, the register file and the valid pipeline.

## Test plan
- Identity load, ReLU off:
  - Stimulus: w[0]=[1,0,0,0], w[1]=[0,1,0,0], biases 0, x=[5,−3,7,2] in cycle c.
  - Response: output_valid in c+3, y=[5,−3], sat_flag=0.
  - With NEURAL_RELU_EN defined, y=[5,0].
- Positive saturation: all weights −128, b[0]=100, x all −128 → acc=65636, y[0]=32767, sat_flag=1.
- Negative saturation, ReLU off: w[1] all 127, x all −128 → y[1]=−32768, sat_flag=1.
- Streaming:
  - Stimulus: four back-to-back samples x=[1,1,1,1]…[4,4,4,4], all weights 1, b=[0,−1].
  - Response: four consecutive outputs y=[4,3],[8,7],[12,11],[16,15], with output_valid high for exactly four cycles.
- Weight update mid-stream:
  - Stimulus: write w[0][0]=2 in the same cycle as sample A, then sample B next cycle; x=[3,0,0,0], w[0][0] was 1.
  - Response: A gives y[0]=6 and B gives y[0]=6. A sample presented in the cycle before the write gives 3.
- Reset mid-stream:
  - Stimulus: rst=0 asserted 1 cycle after two valid samples.
  - Response: output_valid stays 0, outputs read 0, and weights read back as 0 (a subsequent sample gives y=[0,0]).
